// File: rtl/router_pkt_fifo.sv
// Packet-aware output-channel FIFO for the 1x3 router: {tag, data} storage with packet byte tracking.
// Optional read watchdog enabled by defining ROUTER_PKT_FIFO_TIMEOUT_EN.
module router_pkt_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 14,
    parameter int LEN_LSB   = 2,
    parameter int LEN_W     = 6,
    parameter int TO_CYCLES = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     soft_reset,
    input  logic                     w_en,
    input  logic                     r_en,
    input  logic                     lfd_state,
    input  logic [DATA_W-1:0]        d_in,
    output logic [DATA_W-1:0]        d_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [LEN_W:0]           pkt_remaining,
    output logic                     pkt_done,
    output logic                     timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W:0]    mem_r [DEPTH];
    logic [PW-1:0]      w_ptr_r;
    logic [PW-1:0]      r_ptr_r;
    logic [DATA_W-1:0]  d_out_r;
    logic [LEN_W:0]     pkt_rem_r;
    logic               last_rd_r;
    logic               pkt_done_r;

    logic               empty_s;
    logic               full_s;
    logic [PW-1:0]      occ_s;
    logic               wr_ok_s;
    logic               rd_ok_s;
    logic               flush_s;
    logic               fire_s;
    logic [DATA_W:0]    rd_entry_s;
    logic               rd_tag_s;
    logic [LEN_W-1:0]   rd_len_s;

    assign empty_s    = (w_ptr_r == r_ptr_r);
    assign full_s     = (w_ptr_r[AW] != r_ptr_r[AW]) && (w_ptr_r[AW-1:0] == r_ptr_r[AW-1:0]);
    assign occ_s      = w_ptr_r - r_ptr_r;
    assign wr_ok_s    = w_en && !full_s;
    assign rd_ok_s    = r_en && !empty_s;
    assign flush_s    = soft_reset || fire_s;
    assign rd_entry_s = mem_r[r_ptr_r[AW-1:0]];
    assign rd_tag_s   = rd_entry_s[DATA_W];
    assign rd_len_s   = rd_entry_s[LEN_LSB +: LEN_W];

    assign d_out         = d_out_r;
    assign empty         = empty_s;
    assign full          = full_s;
    assign occupancy     = occ_s;
    assign almost_full   = (occ_s >= PW'(AFULL_TH));
    assign pkt_remaining = pkt_rem_r;
    assign pkt_done      = pkt_done_r;

`ifdef ROUTER_PKT_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);

    logic [TW-1:0] to_cnt_r;
    logic          timeout_r;

    assign fire_s  = !empty_s && !rd_ok_s && (to_cnt_r == TW'(TO_CYCLES - 1));
    assign timeout = timeout_r;

    // Watchdog: counts idle cycles while data waits, flushes the channel on expiry.
    always_ff @(posedge clk) begin
        if (reset || soft_reset) begin
            to_cnt_r  <= {TW{1'b0}};
            timeout_r <= 1'b0;
        end else if (fire_s) begin
            to_cnt_r  <= {TW{1'b0}};
            timeout_r <= 1'b1;
        end else if (empty_s || rd_ok_s) begin
            to_cnt_r  <= {TW{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            to_cnt_r  <= to_cnt_r + TW'(1);
            timeout_r <= 1'b0;
        end
    end
`else
    assign fire_s  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s && !reset && !flush_s) begin
            mem_r[w_ptr_r[AW-1:0]] <= {lfd_state, d_in};
        end
    end

    // Pointers, read data register and packet tracking.
    always_ff @(posedge clk) begin
        if (reset || flush_s) begin
            w_ptr_r    <= {PW{1'b0}};
            r_ptr_r    <= {PW{1'b0}};
            d_out_r    <= {DATA_W{1'b0}};
            pkt_rem_r  <= {(LEN_W+1){1'b0}};
            last_rd_r  <= 1'b0;
            pkt_done_r <= 1'b0;
        end else begin
            pkt_done_r <= last_rd_r;
            last_rd_r  <= 1'b0;
            if (wr_ok_s) begin
                w_ptr_r <= w_ptr_r + PW'(1);
            end
            if (rd_ok_s) begin
                r_ptr_r <= r_ptr_r + PW'(1);
                d_out_r <= rd_entry_s[DATA_W-1:0];
                if (rd_tag_s) begin
                    // Header: payload length plus the trailing parity byte.
                    pkt_rem_r <= {1'b0, rd_len_s} + {{LEN_W{1'b0}}, 1'b1};
                end else if (pkt_rem_r != {(LEN_W+1){1'b0}}) begin
                    pkt_rem_r <= pkt_rem_r - {{LEN_W{1'b0}}, 1'b1};
                    last_rd_r <= (pkt_rem_r == {{LEN_W{1'b0}}, 1'b1});
                end
            end
        end
    end

endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
Parametrised packet-aware FIFO for the 1x3 router output channels, one instance per destination port. Each entry stores a data byte plus a header tag bit (lfd_state). On read, the block tracks how many bytes of the current packet are still outstanding and reports packet completion. Full/empty come from extra-MSB pointers, and the block supports simultaneous read/write, a programmable almost-full threshold and occupancy reporting.

Parameters:
DATA_W, 8, data byte width
DEPTH, 16, number of entries; must be a power of 2, minimum 4
AFULL_TH, 14, occupancy at or above which almost_full asserts; 1..DEPTH
LEN_LSB, 2, LSB position of the payload-length field in a header byte
LEN_W, 6, width of the payload-length field; LEN_LSB+LEN_W <= DATA_W
TO_CYCLES, 30, read-timeout limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
soft_reset  in  1  synchronous flush of this channel
w_en  in  1  write request
r_en  in  1  read request
lfd_state  in  1  tag: the current d_in is a packet header
d_in  in  DATA_W  write data
d_out  out  DATA_W  registered read data
empty  out  1  FIFO empty
full  out  1  FIFO full
almost_full  out  1  occupancy >= AFULL_TH
occupancy  out  $clog2(DEPTH)+1  number of stored entries
pkt_remaining  out  LEN_W+1  bytes still to be read in the current packet
pkt_done  out  1  one-cycle pulse when the last byte of a packet is read
timeout  out  1  one-cycle pulse on watchdog flush (0 unless the feature is enabled)

Behaviour:
- Storage: DEPTH entries of DATA_W+1 bits, {tag, data}. Pointers w_ptr and r_ptr are $clog2(DEPTH)+1 bits wide; the memory is addressed by the low bits only. Pointers wrap naturally.
- empty = (w_ptr == r_ptr).
- full = (MSBs differ and low bits equal).
- occupancy = w_ptr - r_ptr, taken modulo 2^(ptr width).
- Write: when w_en && !full, mem[w_ptr] <= {lfd_state, d_in} and w_ptr increments. A write while full is dropped; nothing changes.
- Read: when r_en && !empty, d_out <= data of mem[r_ptr] (1-cycle latency) and r_ptr increments. A read while empty leaves d_out holding its value.
- Simultaneous read and write in the same cycle:
  - Both succeed when legal; occupancy is unchanged.
  - When full, the read succeeds and the write is dropped, because full is sampled before the edge.
  - When empty, the write succeeds and the read is ignored. There is no bypass.
- Packet tracking, evaluated on each successful read:
  - Read entry has tag=1: pkt_remaining <= length field + 1 (payload plus parity byte).
  - Else, if pkt_remaining != 0: decrement pkt_remaining. If it was 1, pkt_done = 1 in the next cycle.
  - Else: pkt_remaining stays 0.
  - A header read while pkt_remaining != 0 reloads the count. No pkt_done is issued for the abandoned packet.
- reset (highest priority) clears:
  - pointers, pkt_remaining and the timeout counter to 0
  - d_out to 0
  - pkt_done and timeout to 0
  - after reset, empty=1, full=0, almost_full=0, occupancy=0
  - memory contents need not be cleared
- soft_reset (below reset) has the same effect as reset on every register and output. A write or read in the same cycle is discarded.
- Memory has no reset.

Optional Feature:
ROUTER_PKT_FIFO_TIMEOUT_EN
- Defined: a watchdog counter, TO_CYCLES-wide enough, runs whenever the FIFO is non-empty.
  - Clears on any successful read, and whenever the FIFO is empty.
  - When the count reaches TO_CYCLES-1 with no read, the next edge performs an internal soft_reset flush and pulses timeout for one cycle.
  - External soft_reset and reset also clear the counter.
- Not defined: the counter logic is absent and timeout is tied to 0.

Test Plan:
- Reset then fill: reset=1 for 2 cycles, then 16 writes of 0x01..0x10 -> full=1 after the 16th write, occupancy=16, almost_full=1 from occupancy 14. A 17th write of 0xFF is dropped. 16 reads return 0x01..0x10 in order, then empty=1.
- Packet count: write header 0x0C with lfd=1 (length 3), then bytes 0xA1, 0xA2, 0xA3 and parity 0x55, then read all 5 -> pkt_remaining sequence 4,3,2,1,0. pkt_done pulses once, in the cycle after 0x55 appears on d_out.
- Simultaneous read/write: occupancy=5, w_en=r_en=1 for 20 cycles -> occupancy stays 5, data stays in order, pointers wrap past 16 correctly. When full with both asserted, the read succeeds, the write is dropped, and occupancy becomes 15.
- Soft reset mid-packet: 3 bytes into a 10-byte packet, assert soft_reset with w_en=1 -> next cycle empty=1, occupancy=0, pkt_remaining=0, d_out=0, and the concurrent write is discarded.
- Empty read: reset, then r_en=1 for 3 cycles -> d_out stays 0x00, r_ptr unchanged, pkt_remaining=0.
- Timeout (with ROUTER_PKT_FIFO_TIMEOUT_EN, TO_CYCLES=30): write 1 byte, then no reads -> timeout pulses 30 cycles after the write, and empty=1 in the same cycle. A read at cycle 29 instead restarts the count and no timeout occurs.
